multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multicycle control FSM for the RV32I subset lw, sw, R-type, I-type ALU, beq and jal.
- Sits upstream of the datapath. Consumes the latched instruction fields and the ALU zero flag, and drives every datapath enable and mux select, one micro-step per cycle.
- Adds a memory-ready handshake and a watchdog so the shared instruction/data memory may stall.

Parameters:
- WAIT_W, 8, width of the memory-wait counter.
- WAIT_LIMIT, 255, number of consecutive stalled cycles in a memory state before a bus error is declared. Must be less than 2^WAIT_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- op  in  7  instruction[6:0], from the instruction register.
- funct3  in  3  instruction[14:12].
- funct7b5  in  1  instruction[30].
- zero  in  1  ALU zero flag.
- memReady  in  1  memory completes the current access this cycle.
- pcWrite  out  1  PC register enable.
- adrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- irWrite  out  1  instruction register enable.
- memWrite  out  1  memory write strobe.
- regWrite  out  1  register file write enable.
- resultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- aluSrcA  out  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = rd1.
- aluSrcB  out  2  ALU operand B select: 00 = rd2, 01 = immExt, 10 = constant 4.
- immSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUcontrol  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- illegal  out  1  one-cycle pulse when an unsupported opcode is decoded.
- busErr  out  1  sticky bus error flag.
- state  out  4  current state, for debug.

Behaviour:
- Reset
  - When reset is high at a rising edge: state <= FETCH, wait counter <= 0, busErr <= 0.
  - While reset is high, all write enables (pcWrite, irWrite, memWrite, regWrite) and illegal are forced to 0.
  - Reset asserted mid-instruction abandons that instruction. No partial writes occur after the reset edge.
- Output decoding
  - All outputs except pcWrite and the memReady-gated strobes are Moore functions of state.
  - Outputs not listed for a state are 0.
- State table
  - FETCH: adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10. irWrite and pcUpdate = memReady. Moves to DECODE when memReady=1, otherwise holds.
  - DECODE: aluSrcA=01, aluSrcB=01, aluOp=00 (computes branch target).
    - op 0000011 or 0100011 -> MEMADR
    - op 0110011 -> EXECUTER
    - op 0010011 -> EXECUTEI
    - op 1100011 -> BEQ
    - op 1101111 -> JAL
    - any other op -> FETCH with illegal=1 for this cycle.
  - MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00. Goes to MEMREAD if op[5]=0, otherwise MEMWRITE.
  - MEMREAD: adrSrc=1, resultSrc=00. Moves to MEMWB when memReady=1, otherwise holds.
  - MEMWB: resultSrc=01, regWrite=1. Goes to FETCH.
  - MEMWRITE: adrSrc=1, resultSrc=00, memWrite=1 for every cycle spent in this state. Goes to FETCH when memReady=1, otherwise holds.
  - EXECUTER: aluSrcA=10, aluSrcB=00, aluOp=10. Goes to ALUWB.
  - EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=10. Goes to ALUWB.
  - ALUWB: resultSrc=00, regWrite=1. Goes to FETCH.
  - BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=1. Goes to FETCH.
  - JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcUpdate=1. Goes to ALUWB (writes rd = PC+4).
- PC enable: pcWrite = pcUpdate | (branch & zero). This is the only Mealy term on zero.
- ALU decode (aluOp is an internal signal)
  - aluOp 00 -> add (000); aluOp 01 -> sub (001).
  - aluOp 10, by funct3:
    - 000: sub if op[5] & funct7b5, otherwise add
    - 010: slt (101)
    - 110: or (011)
    - 111: and (010)
    - any other funct3: add.
- immSrc decode, by op
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - all other op -> 00.
- Watchdog
  - Applies in FETCH, MEMREAD and MEMWRITE.
  - The counter increments on each cycle with memReady=0 and clears on memReady=1 or on any state change.
  - When the counter reaches WAIT_LIMIT: busErr <= 1 (sticky until reset), and the next state is FETCH with no register write and the PC unchanged.
- Nominal latency (memReady held at 1):
  - lw: 5 cycles
  - sw, R-type, I-type, jal: 4 cycles
  - beq: 3 cycles.

Test Plan:
- Reset held 2 cycles, then released; memReady=1, op=0110011, funct3=000, funct7b5=1 -> state sequence FETCH, DECODE, EXECUTER, ALUWB. ALUcontrol=001 in EXECUTER; regWrite=1 only in ALUWB; pcWrite=1 only in FETCH.
- lw (op=0000011) with memReady=0 for 3 cycles in MEMREAD -> state holds in MEMREAD for 3 cycles with regWrite=0; MEMWB is reached 1 cycle after memReady=1; total 8 cycles.
- beq with zero=1, then beq with zero=0 -> pcWrite=1 in the BEQ state only for the first; each instruction takes 3 cycles; ALUcontrol=001 in BEQ.
- jal (op=1101111) -> sequence FETCH, DECODE, JAL, ALUWB; pcWrite=1 in JAL; immSrc=11; regWrite=1 with resultSrc=00 in ALUWB.
- op=0001111 -> illegal=1 for exactly one cycle in DECODE; state then returns to FETCH; no regWrite or memWrite assertion.
- sw with memReady stuck at 0 and WAIT_LIMIT=4 -> memWrite held for 4 cycles, then busErr=1 and state=FETCH; busErr stays 1 until reset; reset asserted during MEMWRITE -> memWrite=0 on the following cycle.

Source files
------------

// File: rtl/multicycle_if.sv
// Control/datapath bundle for the multicycle RV32I controller.
// The controller uses the master modport and the datapath uses the slave modport.
interface multicycle_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       memReady;
    logic       pcWrite;
    logic       adrSrc;
    logic       irWrite;
    logic       memWrite;
    logic       regWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] immSrc;
    logic [2:0] ALUcontrol;
    logic       illegal;
    logic       busErr;
    logic [3:0] state;

    modport master (
        input  op, funct3, funct7b5, zero, memReady,
        output pcWrite, adrSrc, irWrite, memWrite, regWrite, resultSrc,
               aluSrcA, aluSrcB, immSrc, ALUcontrol, illegal, busErr, state
    );

    modport slave (
        output op, funct3, funct7b5, zero, memReady,
        input  pcWrite, adrSrc, irWrite, memWrite, regWrite, resultSrc,
               aluSrcA, aluSrcB, immSrc, ALUcontrol, illegal, busErr, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the RV32I subset lw/sw/R/I/beq/jal.
// Includes a memory-ready handshake and a watchdog that flags stalled memory.
module multicycle_control #(
    parameter int WAIT_W     = 8,
    parameter int WAIT_LIMIT = 255
) (
    input  logic         clk,
    input  logic         reset,
    multicycle_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    state_t            cur, nxt;
    logic [WAIT_W-1:0] waitcnt, waitcnt_nxt;
    logic              buserr_q;
    logic [1:0]        aluop;
    logic              branch, pcupdate;
    logic              irwrite_c, memwrite_c, regwrite_c, illegal_c;
    logic              adrsrc_c;
    logic [1:0]        resultsrc_c, alusrca_c, alusrcb_c;
    logic              memstate, stalled, timeout;
    logic [2:0]        alucontrol_c;
    logic [1:0]        immsrc_c;

    // Watchdog only counts while parked in a state that waits on memory.
    always_comb begin
        memstate = (cur == FETCH) || (cur == MEMREAD) || (cur == MEMWRITE);
        stalled  = memstate && !bus.memReady;
        timeout  = stalled && (waitcnt == WAIT_LAST);
        waitcnt_nxt = (stalled && !timeout) ? waitcnt + WAIT_W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur      <= FETCH;
            waitcnt  <= '0;
            buserr_q <= 1'b0;
        end else begin
            cur     <= nxt;
            waitcnt <= waitcnt_nxt;
            if (timeout) buserr_q <= 1'b1;
        end
    end

    always_comb begin
        nxt         = cur;
        aluop       = 2'b00;
        branch      = 1'b0;
        pcupdate    = 1'b0;
        irwrite_c   = 1'b0;
        memwrite_c  = 1'b0;
        regwrite_c  = 1'b0;
        illegal_c   = 1'b0;
        adrsrc_c    = 1'b0;
        resultsrc_c = 2'b00;
        alusrca_c   = 2'b00;
        alusrcb_c   = 2'b00;
        unique case (cur)
            FETCH: begin
                alusrcb_c   = 2'b10;
                resultsrc_c = 2'b10;
                irwrite_c   = bus.memReady;
                pcupdate    = bus.memReady;
                if (bus.memReady) nxt = DECODE;
            end
            DECODE: begin
                alusrca_c = 2'b01;
                alusrcb_c = 2'b01;
                case (bus.op)
                    7'b0000011, 7'b0100011: nxt = MEMADR;
                    7'b0110011:             nxt = EXECUTER;
                    7'b0010011:             nxt = EXECUTEI;
                    7'b1100011:             nxt = BEQ;
                    7'b1101111:             nxt = JAL;
                    default: begin
                        nxt       = FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca_c = 2'b10;
                alusrcb_c = 2'b01;
                nxt       = bus.op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adrsrc_c = 1'b1;
                if (bus.memReady) nxt = MEMWB;
            end
            MEMWB: begin
                resultsrc_c = 2'b01;
                regwrite_c  = 1'b1;
                nxt         = FETCH;
            end
            MEMWRITE: begin
                adrsrc_c   = 1'b1;
                memwrite_c = 1'b1;
                if (bus.memReady) nxt = FETCH;
            end
            EXECUTER: begin
                alusrca_c = 2'b10;
                aluop     = 2'b10;
                nxt       = ALUWB;
            end
            EXECUTEI: begin
                alusrca_c = 2'b10;
                alusrcb_c = 2'b01;
                aluop     = 2'b10;
                nxt       = ALUWB;
            end
            ALUWB: begin
                regwrite_c = 1'b1;
                nxt        = FETCH;
            end
            BEQ: begin
                alusrca_c = 2'b10;
                aluop     = 2'b01;
                branch    = 1'b1;
                nxt       = FETCH;
            end
            JAL: begin
                alusrca_c = 2'b01;
                alusrcb_c = 2'b10;
                pcupdate  = 1'b1;
                nxt       = ALUWB;
            end
            default: nxt = FETCH;
        endcase
        // A timed-out access abandons the instruction; FETCH/MEMREAD/MEMWRITE never update PC or rd here.
        if (timeout) nxt = FETCH;
    end

    always_comb begin
        alucontrol_c = 3'b000;
        case (aluop)
            2'b01: alucontrol_c = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  alucontrol_c = (bus.op[5] && bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alucontrol_c = 3'b101;
                    3'b110:  alucontrol_c = 3'b011;
                    3'b111:  alucontrol_c = 3'b010;
                    default: alucontrol_c = 3'b000;
                endcase
            end
            default: alucontrol_c = 3'b000;
        endcase
    end

    always_comb begin
        case (bus.op)
            7'b0100011: immsrc_c = 2'b01;
            7'b1100011: immsrc_c = 2'b10;
            7'b1101111: immsrc_c = 2'b11;
            default:    immsrc_c = 2'b00;
        endcase
    end

    assign bus.pcWrite    = !reset && (pcupdate || (branch && bus.zero));
    assign bus.irWrite    = !reset && irwrite_c;
    assign bus.memWrite   = !reset && memwrite_c;
    assign bus.regWrite   = !reset && regwrite_c;
    assign bus.illegal    = !reset && illegal_c;
    assign bus.adrSrc     = adrsrc_c;
    assign bus.resultSrc  = resultsrc_c;
    assign bus.aluSrcA    = alusrca_c;
    assign bus.aluSrcB    = alusrcb_c;
    assign bus.immSrc     = immsrc_c;
    assign bus.ALUcontrol = alucontrol_c;
    assign bus.busErr     = buserr_q;
    assign bus.state      = cur;

endmodule
